// File: rtl/cb_pulse_meas.sv
// Pulse high-time / period meter for a clean, clk_sys-synchronous line, with stall timeout.
// Optional rising-edge counter port enabled by defining CB_PULSE_MEAS_EDGE_CNT_EN.
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_IDLE      | measurement off, run/high counters held at 0
// ST_WAIT_RISE | enabled, waiting for an arming rise; timeout counting active
// ST_MEAS      | armed; counting period/high time, publishing on every rise
module cb_pulse_meas #(
  parameter int U_DLY = 1,
  parameter int CNT_W = 32
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             meas_en,
  input  logic [CNT_W-1:0] timeout_cnt,
  input  logic             sig_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_vld,
  output logic             meas_timeout,
  output logic             meas_busy
`ifdef CB_PULSE_MEAS_EDGE_CNT_EN
  ,
  output logic [CNT_W-1:0] edge_cnt
`endif
);

  if (CNT_W < 8 || CNT_W > 32 || U_DLY < 0) begin : g_param_chk
    $error("cb_pulse_meas: CNT_W must be within 8..32 and U_DLY non-negative");
  end

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_RISE = 2'd1,
    ST_MEAS      = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic             sig_d;
  logic             rise;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] run_nxt;
  logic [CNT_W-1:0] hi_run;
  logic [CNT_W-1:0] hi_nxt;
  logic [CNT_W-1:0] run_inc;
  logic [CNT_W-1:0] hi_inc;
  logic             tout_hit;
  logic             take_meas;
  logic             tout_evt;

  assign rise      = sig_in & ~sig_d;
  assign run_inc   = (run_cnt == CNT_MAX) ? run_cnt : run_cnt + CNT_ONE;
  assign hi_inc    = (hi_run == CNT_MAX || !sig_in) ? hi_run : hi_run + CNT_ONE;
  assign tout_hit  = (timeout_cnt != '0) && (run_cnt >= timeout_cnt);
  assign meas_busy = (state != ST_IDLE);

  // Priority in every active state: disable, then rise, then timeout.
  always_comb begin
    state_nxt = state;
    run_nxt   = run_cnt;
    hi_nxt    = hi_run;
    take_meas = 1'b0;
    tout_evt  = 1'b0;
    case (state)
      ST_IDLE: begin
        run_nxt = '0;
        hi_nxt  = '0;
        if (meas_en) state_nxt = ST_WAIT_RISE;
      end
      ST_WAIT_RISE: begin
        if (!meas_en) begin
          state_nxt = ST_IDLE;
          run_nxt   = '0;
          hi_nxt    = '0;
        end else if (rise) begin
          state_nxt = ST_MEAS;
          run_nxt   = CNT_ONE;
          hi_nxt    = CNT_ONE;
        end else if (tout_hit) begin
          tout_evt = 1'b1;
          run_nxt  = '0;
          hi_nxt   = '0;
        end else begin
          run_nxt = run_inc;
        end
      end
      ST_MEAS: begin
        if (!meas_en) begin
          state_nxt = ST_IDLE;
          run_nxt   = '0;
          hi_nxt    = '0;
        end else if (rise) begin
          take_meas = 1'b1;
          run_nxt   = CNT_ONE;
          hi_nxt    = CNT_ONE;
        end else if (tout_hit) begin
          tout_evt  = 1'b1;
          state_nxt = ST_WAIT_RISE;
          run_nxt   = '0;
          hi_nxt    = '0;
        end else begin
          run_nxt = run_inc;
          hi_nxt  = hi_inc;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        run_nxt   = '0;
        hi_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      sig_d        <= 1'b0;
      run_cnt      <= '0;
      hi_run       <= '0;
      high_cnt     <= '0;
      period_cnt   <= '0;
      meas_vld     <= 1'b0;
      meas_timeout <= 1'b0;
    end else begin
      state        <= state_nxt;
      sig_d        <= sig_in;
      run_cnt      <= run_nxt;
      hi_run       <= hi_nxt;
      meas_vld     <= take_meas;
      meas_timeout <= tout_evt;
      if (take_meas) begin
        period_cnt <= run_cnt;
        high_cnt   <= hi_run;
      end
    end
  end

`ifdef CB_PULSE_MEAS_EDGE_CNT_EN
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (meas_en) edge_cnt <= '0;
    end else if (rise && edge_cnt != CNT_MAX) begin
      edge_cnt <= edge_cnt + CNT_ONE;
    end
  end
`endif

endmodule
